serial_frame_receiver: RTL and testbench

Consumes the registered serial bit stream from the master-slave D flip-flop stage, where D is sampled once per Clk. Detects a start bit and deserializes WIDTH data bits, LSB first, then checks a stop bit. Presents the captured word on a parallel port with a one-cycle Valid strobe, or flags a framing error. Sits directly downstream of the flip-flop synchronizer and upstream of parallel consumers such as registers, counters and displays.

---
 rtl/serial_rx_pkg.sv | 19 +
 rtl/serial_shift_reg.sv | 38 +++
 rtl/serial_frame_receiver.sv | 159 +++++++++++++++
 tb/tb_serial_frame_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared types and constants for the serial frame receiver.
// The PARITY state stays in the enum in every build. The parity-enabled
// build is selected by the SERIAL_RX_PARITY_EN macro in serial_frame_receiver.
`timescale 1ns/1ps
package serial_rx_pkg;

    // Default number of data bits per frame
    localparam int SERIAL_RX_DEFAULT_WIDTH = 8;

    // Receiver FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;

endpackage : serial_rx_pkg

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: WIDTH-bit right-shift register.
// When enabled, each rising edge shifts the serial input into the MSB.
// After WIDTH shifts, the first bit shifted in sits in bit 0.
// The register is also meant to be reused by serializer logic.
`timescale 1ns/1ps
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             shift_en,
    input  logic             Din,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next value: shift right with Din entering the MSB, otherwise hold
    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            sr_d = {Din, sr_q[WIDTH-1:1]};
        end
    end

    // Shift register storage, cleared by asynchronous reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_out = sr_q;

endmodule : serial_shift_reg

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: takes a registered serial bit stream, sampled once
// per Clk. It finds a start bit (0) and shifts in WIDTH data bits, LSB first,
// then checks the stop bit (1). A good frame updates Data and pulses Valid
// for one cycle. A bad stop bit pulses FrameErr for one cycle, and the FSM
// then waits in BREAK until the line returns high.
// Build option: defining SERIAL_RX_PARITY_EN inserts an even-parity bit
// between the data and the stop bit. A parity failure ends the frame with
// FrameErr whatever the stop bit value.
`timescale 1ns/1ps
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = SERIAL_RX_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Din,
    output logic [WIDTH-1:0] Data,
    output logic             Valid,
    output logic             FrameErr,
    output logic             Busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             shift_en;
    logic [WIDTH-1:0] shift_word;
    logic             stop_ok;

`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    // Data bits are shifted in only while in DATA
    assign shift_en = (state_q == DATA);

    serial_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .Clk      (Clk),
        .Rst      (Rst),
        .shift_en (shift_en),
        .Din      (Din),
        .par_out  (shift_word)
    );

    // A stop bit completes a good frame only if the line is high
    // and, when parity is built in, the parity check passed
`ifdef SERIAL_RX_PARITY_EN
    assign stop_ok = Din && !parity_err_q;
`else
    assign stop_ok = Din;
`endif

    // Next-state, counter and output-strobe logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A low line is a start bit; the counter restarts at each frame
                if (!Din) begin
                    state_d = DATA;
                    cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
                    parity_err_d = 1'b0;
`endif
                end
            end
            DATA: begin
                // The counter holds at its last value instead of wrapping
                if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                // Even parity: XOR of the data bits and the parity bit must be 0
                parity_err_d = (^shift_word) ^ Din;
                state_d      = STOP;
            end
`endif
            STOP: begin
                if (stop_ok) begin
                    data_d  = shift_word;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    // A low stop bit means the line may be held low; wait in BREAK
                    state_d     = Din ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Stay here until the line returns high so that a held-low
                // line cannot start a new frame
                if (Din) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers with asynchronous reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Parity result from the PARITY state, used at the following STOP
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

    assign Data     = data_q;
    assign Valid    = valid_q;
    assign FrameErr = frame_err_q;
    assign Busy     = (state_q != IDLE);

endmodule : serial_frame_receiver

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed tests for serial_frame_receiver with WIDTH=8.
// Din is driven on falling edges, and outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_serial_frame_receiver;

    localparam int W = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FRAME_BITS = W + 3;
`else
    localparam int FRAME_BITS = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic [W-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Event log filled by the monitor
    int           cyc       = 0;
    int           n_valid   = 0;
    int           n_err     = 0;
    int           n_overlap = 0;
    int           n_long    = 0;
    logic         prev_valid = 1'b0;
    logic         prev_err   = 1'b0;
    logic [W-1:0] got_q[$];
    int           vcyc_q[$];

`ifdef SERIAL_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    serial_frame_receiver #(
        .WIDTH (W)
    ) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Din      (din),
        .Data     (data),
        .Valid    (valid),
        .FrameErr (frame_err),
        .Busy     (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Counts rising edges
    always @(posedge clk) cyc = cyc + 1;

    // Records every Valid and FrameErr pulse, and flags overlapping or
    // over-long pulses
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid = n_valid + 1;
            got_q.push_back(data);
            vcyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) n_err = n_err + 1;
        if (valid === 1'b1 && frame_err === 1'b1) n_overlap = n_overlap + 1;
        if ((valid === 1'b1 && prev_valid === 1'b1) || (frame_err === 1'b1 && prev_err === 1'b1))
            n_long = n_long + 1;
        prev_valid = valid;
        prev_err   = frame_err;
    end

    // Driver tasks
    task automatic send_bit(input logic b);
        @(negedge clk);
        din = b;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    // Reset values while Rst is held
    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        #2;
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // An idle line (Din=1) starts no frame
    task automatic test_idle();
        idle(20);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL idle_frame_err got=%b exp=0", frame_err); end
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL idle_data got=%h exp=00", data); end
        n_checks++; if (n_valid !== 0 || n_err !== 0) begin n_fail++; $display("FAIL idle_pulses got valid=%0d err=%0d exp=0/0", n_valid, n_err); end
    endtask

    // Single 0xA5 frame, with Busy and Valid checked cycle by cycle
    task automatic test_basic();
        logic [W-1:0] d;
        d = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < W; i++) begin
            send_bit(d[i]);
            n_checks++; if (busy !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL basic_busy_bit%0d got busy=%b valid=%b exp busy=1 valid=0", i, busy, valid); end
        end
`ifdef SERIAL_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(1'b1);
        n_checks++; if (busy !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL basic_busy_stop got busy=%b valid=%b exp busy=1 valid=0", busy, valid); end
        send_bit(1'b1);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", valid); end
        n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got=%h exp=a5", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err got=%b exp=0", frame_err); end
        send_bit(1'b1);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width got=%b exp=0", valid); end
        n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_data_hold got=%h exp=a5", data); end
    endtask

    // Two frames with no idle gap between them
    task automatic test_back_to_back();
        got_q.delete();
        vcyc_q.delete();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(3);
        n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_checks++; if (got_q[0] !== 8'h3C) begin n_fail++; $display("FAIL b2b_data0 got=%h exp=3c", got_q[0]); end
            n_checks++; if (got_q[1] !== 8'hC3) begin n_fail++; $display("FAIL b2b_data1 got=%h exp=c3", got_q[1]); end
            n_checks++; if (vcyc_q[1] - vcyc_q[0] !== FRAME_BITS) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", vcyc_q[1] - vcyc_q[0], FRAME_BITS); end
        end
    endtask

    // Bad stop bit, then the line held low, then the line released
    task automatic test_framing_error();
        int base_v;
        int base_e;
        base_v = n_valid;
        base_e = n_err;
        send_frame(8'hFF, 1'b0);
        send_bit(1'b0);
        n_checks++; if (frame_err !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL ferr_pulse got err=%b valid=%b exp err=1 valid=0", frame_err, valid); end
        n_checks++; if (data !== 8'hC3) begin n_fail++; $display("FAIL ferr_data_kept got=%h exp=c3", data); end
        for (int i = 1; i < 5; i++) begin
            send_bit(1'b0);
            n_checks++; if (busy !== 1'b1 || frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_break_%0d got busy=%b err=%b exp busy=1 err=0", i, busy, frame_err); end
        end
        send_bit(1'b1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_last got=%b exp=1", busy); end
        idle(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_released got=%b exp=0", busy); end
        n_checks++; if (n_err - base_e !== 1 || n_valid - base_v !== 0) begin n_fail++; $display("FAIL ferr_counts got err=%0d valid=%0d exp 1/0", n_err - base_e, n_valid - base_v); end
        send_frame(8'h12, 1'b1);
        idle(2);
        n_checks++; if (data !== 8'h12) begin n_fail++; $display("FAIL ferr_recover got=%h exp=12", data); end
    endtask

    // Reset in the middle of a frame, then a clean frame
    task automatic test_mid_reset();
        int base_v;
        int base_e;
        logic [W-1:0] d;
        d = 8'h5A;
        base_v = n_valid;
        base_e = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        @(negedge clk);
        #1;
        rst = 1'b1;
        din = 1'b1;
        #1;
        n_checks++; if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mreset_outputs got data=%h valid=%b err=%b busy=%b exp all 0", data, valid, frame_err, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        n_checks++; if (n_valid - base_v !== 0 || n_err - base_e !== 0) begin n_fail++; $display("FAIL mreset_aborted got valid=%0d err=%0d exp 0/0", n_valid - base_v, n_err - base_e); end
        send_frame(8'h81, 1'b1);
        idle(3);
        n_checks++; if (data !== 8'h81) begin n_fail++; $display("FAIL mreset_data got=%h exp=81", data); end
        n_checks++; if (n_valid - base_v !== 1 || n_err - base_e !== 0) begin n_fail++; $display("FAIL mreset_counts got valid=%0d err=%0d exp 1/0", n_valid - base_v, n_err - base_e); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: a good parity bit gives Valid, a bad one gives FrameErr
    task automatic test_parity();
        int base_v;
        int base_e;
        base_v = n_valid;
        base_e = n_err;
        par_flip = 1'b0;
        send_frame(8'hA5, 1'b1);
        idle(3);
        n_checks++; if (data !== 8'hA5 || n_valid - base_v !== 1 || n_err - base_e !== 0) begin
            n_fail++; $display("FAIL parity_good got data=%h valid=%0d err=%0d exp a5 1/0", data, n_valid - base_v, n_err - base_e);
        end
        send_frame(8'h3C, 1'b1);
        idle(3);
        base_v = n_valid;
        base_e = n_err;
        par_flip = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(3);
        par_flip = 1'b0;
        n_checks++; if (data !== 8'h3C || n_valid - base_v !== 0 || n_err - base_e !== 1) begin
            n_fail++; $display("FAIL parity_bad got data=%h valid=%0d err=%0d exp 3c 0/1", data, n_valid - base_v, n_err - base_e);
        end
    endtask
`endif

    // Pulse properties collected over the whole run
    task automatic test_pulse_rules();
        n_checks++; if (n_overlap !== 0) begin n_fail++; $display("FAIL pulse_overlap got=%0d exp=0", n_overlap); end
        n_checks++; if (n_long !== 0) begin n_fail++; $display("FAIL pulse_width got=%0d exp=0", n_long); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_back_to_back();
        test_framing_error();
        test_mid_reset();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_frame_receiver
